// File: rtl/serial_logic_unit_if.sv
// rtl/serial_logic_unit_if.sv - request/result bundle for serial_logic_unit
interface serial_logic_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, op, in1, in2,
    input  out, busy, done, err
  );

  modport slave (
    input  start, op, in1, in2,
    output out, busy, done, err
  );
endinterface

// File: rtl/serial_logic_unit.sv
// rtl/serial_logic_unit.sv - bit-serial AND/OR (XOR when SLU_XOR_EN is defined) logic slice
module serial_logic_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_logic_unit_if.slave  bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, acc, out_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    count;
  logic             illegal, busy_q, done_q, err_q;
  logic             legal_op, accept, last;
  logic [STEP-1:0]  r;

  always_comb begin
`ifdef SLU_XOR_EN
    legal_op = (bus.op != 2'b11);
`else
    legal_op = ~bus.op[1];
`endif
  end

  // busy_q stays high through the done cycle, which forces one idle cycle before the next accept
  assign accept = (state == IDLE) && !busy_q && bus.start;
  assign last   = (count == CW'(N - 1));

  always_comb begin
    r = '0;
    case (op_q)
      2'b00:   r = a[STEP-1:0] & b[STEP-1:0];
      2'b01:   r = a[STEP-1:0] | b[STEP-1:0];
`ifdef SLU_XOR_EN
      2'b10:   r = a[STEP-1:0] ^ b[STEP-1:0];
`endif
      default: r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal_op ? RUN : DONE;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      out_q   <= '0;
      op_q    <= 2'b00;
      count   <= '0;
      illegal <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (done_q) busy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy_q  <= 1'b1;
            acc     <= '0;
            count   <= '0;
            illegal <= !legal_op;
            if (legal_op) begin
              a    <= bus.in1;
              b    <= bus.in2;
              op_q <= bus.op;
            end
          end
        end
        RUN: begin
          acc <= {r, acc[WIDTH-1:STEP]};
          a   <= a >> STEP;
          b   <= b >> STEP;
          if (!last) count <= count + 1'b1;
        end
        DONE: begin
          out_q  <= illegal ? '0 : acc;
          err_q  <= illegal;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_serial_logic_unit.sv
// tb/tb_serial_logic_unit.sv - scoreboard bench for serial_logic_unit (STEP=4 and STEP=1 instances)
module tb_serial_logic_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_logic_unit_if #(.WIDTH(32)) bus  ();
  serial_logic_unit_if #(.WIDTH(32)) bus1 ();

  serial_logic_unit #(.WIDTH(32), .STEP(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  serial_logic_unit #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [31:0] out;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   chk_after = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_after) begin
      check("done_width", 32'(bus.done), 32'd0);
      check("busy_after_done", 32'(bus.busy), 32'd0);
    end
    chk_after = 0;
    if (bus.done === 1'b1) begin
      chk_after = 1;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        check({e.name, "_out"}, bus.out, e.out);
        check({e.name, "_err"}, 32'(bus.err), 32'(e.err));
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_busy"}, 32'(bus.busy), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus1.done === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done_step1: got done=1 expected 0");
      end else begin
        e = q1.pop_front();
        check({e.name, "_out"}, bus1.out, e.out);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic ee, input int lat, input string name);
    exp_t e;
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.in1   = a;
    bus.in2   = b;
    e.out = eo; e.err = ee; e.cyc = cyc + 1 + lat; e.name = name;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.in1   = $urandom;
    bus.in2   = $urandom;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.in1 = '0; bus.in2 = '0;
    bus1.start = 1'b0; bus1.op = 2'b00; bus1.in1 = '0; bus1.in2 = '0;
    repeat (2) @(negedge clk);
    check("reset_out", bus.out, 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'h0000A5A5, 32'h00005A5A, 32'h00000000, 1'b0, 9, "and_a5");
    wait_empty("and_a5");
    issue(2'b01, 32'h0000A5A5, 32'h00005A5A, 32'h0000FFFF, 1'b0, 9, "or_a5");
    wait_empty("or_a5");
    issue(2'b01, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 9, "or_ones");
    wait_empty("or_ones");

    // restart attempt during RUN must be ignored
    issue(2'b00, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0, 9, "busy_prot");
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.in1 = 32'hFFFFFFFF; bus.in2 = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_empty("busy_prot");
    repeat (15) @(negedge clk);

    bus.start = 1'b1; bus.op = 2'b00; bus.in1 = 32'hFFFFFFFF; bus.in2 = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out", bus.out, 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 9, "after_abort");
    wait_empty("after_abort");

    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, "illegal");
    wait_empty("illegal");
    issue(2'b00, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0, 9, "err_clear");
    wait_empty("err_clear");

`ifdef SLU_XOR_EN
    issue(2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 9, "xor");
`else
    issue(2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1, "xor_off");
`endif
    wait_empty("xor");

    begin
      exp_t e;
      int n = 0;
      bus1.start = 1'b1; bus1.op = 2'b00; bus1.in1 = 32'h12345678; bus1.in2 = 32'h0F0F0F0F;
      e.out = 32'h02040608; e.err = 1'b0; e.cyc = cyc + 1 + 33; e.name = "step1_and";
      q1.push_back(e);
      @(negedge clk);
      bus1.start = 1'b0; bus1.in1 = '0; bus1.in2 = '0;
      while (q1.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (q1.size() != 0) begin
        total++;
        bad++;
        $display("FAIL step1_timeout: got %0d pending expected 0", q1.size());
      end
      repeat (2) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_logic_unit.md
# serial_logic_unit

Multi-cycle, bit-serial counterpart to the 32-bit word-parallel AND/OR blocks in the Lab4 ALU path.
- Captures two operands on a start handshake and consumes them STEP bits per cycle from the LSB end.
- Rebuilds the logic result in an accumulator and presents it on a registered output with a one-cycle done pulse.
- Intended as the area-reduced logic slice for the multi-cycle datapath.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of STEP.
- STEP, 4: bits processed per cycle; N = WIDTH/STEP.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  operation code: 00 AND, 01 OR, 10 XOR (only with SLU_XOR_EN), 11 illegal.
- in1  input  WIDTH  operand A, captured on accepted start.
- in2  input  WIDTH  operand B, captured on accepted start.
- out  output  WIDTH  registered result; holds until the next done.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when out is updated.
- err  output  1  registered; set with done for an illegal op, cleared on the next done with a legal op.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE with out=0, busy=0, done=0, err=0, shift registers/accumulator/counter=0.
- IDLE, start=1, legal op:
  - Load in1/in2 into shift registers a/b; latch op.
  - Clear the accumulator; set count=0; go to RUN.
- IDLE, start=1, illegal op: go directly to DONE with the pending result forced to 0 and err pending =1.
- RUN, each cycle:
  - r = a[STEP-1:0] op b[STEP-1:0].
  - Shift the accumulator right by STEP, inserting r at [WIDTH-1:WIDTH-STEP].
  - Shift a and b right by STEP (zero fill).
  - count increments; on count = N-1, go to DONE.
- DONE: out <= accumulator (or 0 for illegal); err updated; done=1 for this cycle; then go to IDLE.
- start while busy=1 (RUN or DONE) is ignored; captured operands are unaffected by in1/in2/op changes after acceptance.
- Counter width is clog2(N) (minimum 1); no wrap beyond N-1.
- rst_n low mid-operation: immediate abort to IDLE, out=0, no done pulse.

## Timing
- Start accepted at edge T (busy rises after T).
- Legal op: RUN occupies cycles T+1..T+N; done high in the cycle after edge T+N+1, with out/err valid in that same cycle. Latency N+1 edges (default 9; STEP=1 gives 33).
- Illegal op: done after edge T+1 (latency 1 edge).
- busy falls together with done falling. The earliest next accepted start is at the edge that ends the done cycle's successor, i.e. one idle cycle is mandatory.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SLU_XOR_EN defined: op=10 computes bitwise XOR with the same latency; only 11 is illegal.
- SLU_XOR_EN undefined: op=10 and op=11 are both illegal (err=1, out=0, 1-edge latency). No XOR logic is synthesized.

## Test plan
- AND, defaults: in1=0000A5A5, in2=00005A5A, op=00, start for one cycle -> after 9 edges done=1 for exactly one cycle, out=00000000, err=0, busy low the next cycle.
- OR: same operands, op=01 -> out=0000FFFF at 9-edge latency. Then in1=FFFFFFFF, in2=0 -> out=FFFFFFFF.
- Busy protection: start AND on 12345678/0F0F0F0F, re-pulse start with op=01 and new operands at RUN cycle 3 -> single done, out=02040608, no second done.
- Reset mid-run: assert rst_n=0 at RUN cycle 5 -> out=0, busy=0, done never pulses. A subsequent legal op completes normally.
- Illegal op: op=11 -> done after 1 edge, out=0, err=1. Next legal AND clears err to 0.
- SLU_XOR_EN defined, op=10, FFFF0000 ^ 0F0F0F0F -> out=F0F00F0F. Without the macro, the same stimulus -> err=1, out=0. Repeat the AND case with STEP=1 -> latency 33 edges.
